// File: rtl/inverse_pdm.sv
// PDM demodulator: counts ones over a 2^WIN_BITS clock window and reports a 16-bit duty value.
// Optional `INV_PDM_AVG_EN reports the average of the current and previous window results.
module inverse_pdm #(
  parameter int unsigned WIN_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PDM,
  output logic [15:0] duty,
  output logic        done
);

  localparam int unsigned SHIFT = 16 - WIN_BITS;

  logic                pdm_meta_q;
  logic                pdm_s_q;
  logic [WIN_BITS-1:0] win_cnt_q;
  logic [WIN_BITS:0]   acc_q;
  logic [WIN_BITS:0]   acc_d;
  logic [WIN_BITS:0]   total;
  logic [31:0]         scaled;
  logic [15:0]         scaled_sat;
  logic [15:0]         duty_q;
  logic [15:0]         duty_d;
  logic                done_q;
  logic                done_d;
  logic                end_of_win;

`ifdef INV_PDM_AVG_EN
  logic [15:0] prev_q;
  logic [15:0] prev_d;
  logic [16:0] avg_sum;
`endif

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    end_of_win = &win_cnt_q;
    total      = acc_q + {{WIN_BITS{1'b0}}, pdm_s_q};
    scaled     = {{(31 - WIN_BITS){1'b0}}, total} << SHIFT;
    // A full window of ones scales to 0x10000; clamp so it reads as 100 %, not 0.
    scaled_sat = (scaled > 32'h0000_FFFF) ? 16'hFFFF : scaled[15:0];
    acc_d      = end_of_win ? '0 : total;
    done_d     = end_of_win;
    duty_d     = duty_q;
`ifdef INV_PDM_AVG_EN
    prev_d     = prev_q;
    avg_sum    = {1'b0, prev_q} + {1'b0, scaled_sat};
    if (end_of_win) begin
      duty_d = 16'(avg_sum >> 1);
      prev_d = scaled_sat;
    end
`else
    if (end_of_win) begin
      duty_d = scaled_sat;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pdm_meta_q <= 1'b0;
      pdm_s_q    <= 1'b0;
      win_cnt_q  <= '0;
      acc_q      <= '0;
      duty_q     <= '0;
      done_q     <= 1'b0;
`ifdef INV_PDM_AVG_EN
      prev_q     <= '0;
`endif
    end else begin
      pdm_meta_q <= PDM;
      pdm_s_q    <= pdm_meta_q;
      win_cnt_q  <= win_cnt_q + 1'b1;
      acc_q      <= acc_d;
      duty_q     <= duty_d;
      done_q     <= done_d;
`ifdef INV_PDM_AVG_EN
      prev_q     <= prev_d;
`endif
    end
  end

  assign duty = duty_q;
  assign done = done_q;

endmodule

// File: tb/tb_inverse_pdm.sv
// Self-checking bench for inverse_pdm (WIN_BITS=8): window-sum reference model plus literal checks.
module tb_inverse_pdm;

  localparam int unsigned W = 8;
  localparam int N = 1 << W;

`ifdef INV_PDM_AVG_EN
  localparam logic [15:0] ONES_FIRST  = 16'h7F00;
  localparam logic [15:0] ONES_SECOND = 16'hFEFF;
`else
  localparam logic [15:0] ONES_FIRST  = 16'hFE00;
  localparam logic [15:0] ONES_SECOND = 16'hFFFF;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PDM = 1'b0;
  logic [15:0] duty;
  logic        done;

  int total = 0;
  int bad   = 0;

  inverse_pdm #(.WIN_BITS(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .PDM   (PDM),
    .duty  (duty),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus generator: one PDM value per clock, changed just after the rising edge.
  int mode = 0;
  int dens = 128;
  int t    = 0;
  always @(posedge clk) begin
    #1;
    t++;
    case (mode)
      0:       PDM = 1'b0;
      1:       PDM = 1'b1;
      2:       PDM = t[0];
      3:       PDM = (t % 4 == 0);
      default: PDM = ($urandom_range(0, 255) < dens);
    endcase
  end

  // Reference model: the sample counted on clock k after reset is the input
  // seen two clocks earlier (zero for k<=2); window n sums clocks nN+1..(n+1)N.
  int          cyc;
  bit          hist[$];
  logic [15:0] m_duty;
  logic [15:0] m_prev;
  logic        m_done;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      hist.delete();
      m_duty = 16'h0;
      m_prev = 16'h0;
      m_done = 1'b0;
    end else begin
      cyc++;
      hist.push_back(PDM);
      m_done = (cyc % N == 0);
      if (m_done) begin
        int ones;
        int val;
        ones = 0;
        for (int k = cyc - N + 1; k <= cyc; k++)
          if (k >= 3 && hist[k-3]) ones++;
        val = ones * (65536 / N);
        if (val > 65535) val = 65535;
`ifdef INV_PDM_AVG_EN
        m_duty = 16'((int'(m_prev) + val) / 2);
        m_prev = 16'(val);
`else
        m_duty = 16'(val);
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("done_vs_model", {31'b0, done}, {31'b0, m_done});
      check("duty_vs_model", {16'b0, duty}, {16'b0, m_duty});
    end
  end

  task automatic apply_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("reset_duty", {16'b0, duty}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done && cycles < 2 * N + 8);
    if (!done) check("done_timeout", 32'h0, 32'h1);
  endtask

  int cyc_seen;

  initial begin
    // All zeros: first done exactly one window after release, duty stays 0.
    mode = 0;
    apply_reset();
    wait_done(cyc_seen);
    check("zeros_first_latency", cyc_seen, N);
    check("zeros_duty1", {16'b0, duty}, 32'h0);
    wait_done(cyc_seen);
    check("zeros_period", cyc_seen, N);
    check("zeros_duty2", {16'b0, duty}, 32'h0);
    @(negedge clk);
    check("done_one_cycle", {31'b0, done}, 32'h0);

    // All ones: two flush zeros in the first window, saturation afterwards.
    mode = 1;
    apply_reset();
    wait_done(cyc_seen);
    check("ones_first", {16'b0, duty}, {16'b0, ONES_FIRST});
    wait_done(cyc_seen);
    check("ones_second", {16'b0, duty}, {16'b0, ONES_SECOND});

    // 50 % toggle and 25 % pattern, checked at the third window.
    mode = 2;
    apply_reset();
    repeat (3) wait_done(cyc_seen);
    check("toggle_steady", {16'b0, duty}, 32'h8000);
    mode = 3;
    apply_reset();
    repeat (3) wait_done(cyc_seen);
    check("pat1000_steady", {16'b0, duty}, 32'h4000);

    // Random densities, with a mid-window reset that must restart the window.
    for (int r = 0; r < 4; r++) begin
      dens = $urandom_range(0, 256);
      mode = 4;
      apply_reset();
      repeat (2) wait_done(cyc_seen);
      repeat ($urandom_range(20, N - 20)) @(posedge clk);
      mode = 1;
      apply_reset();
      wait_done(cyc_seen);
      check("midreset_latency", cyc_seen, N);
      check("midreset_duty", {16'b0, duty}, {16'b0, ONES_FIRST});
      mode = 4;
      repeat (2) wait_done(cyc_seen);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inverse_pdm.md
Name: inverse_pdm

Overview:
- Bench-side PDM demodulator. It recovers the duty cycle of a 1-bit pulse-density-modulated stream, such as the Equalizer's lft_PDM output.
- It counts ones over a fixed window of clock cycles and reports a 16-bit duty value, scaled so that 0xFFFF means 100 % ones.
- A single-cycle done strobe marks each new result. The strobe feeds downstream frequency and amplitude analysis.

Parameters:
- WIN_BITS, default 16: the window is 2^WIN_BITS clocks. Legal range is 4..16.

Ports:
- clk, input, 1: system clock. All state changes on the rising edge.
- rst_n, input, 1: reset. Asynchronous and active-low.
- PDM, input, 1: PDM bit stream. It is asynchronous to clk.
- duty, output, 16: duty measured over the last completed window.
- done, output, 1: one-cycle pulse. It is high on the cycle duty is updated.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Synchronizer flops, window counter, ones accumulator, duty and done all clear to 0.
  - Reset asserted mid-window discards the partial window.
- Input conditioning: PDM passes through a 2-flop synchronizer (pdm_s). Sample latency is 2 clocks.
- Window counter:
  - win_cnt is WIN_BITS wide and increments every clock after reset.
  - It wraps from 2^WIN_BITS-1 to 0.
- Accumulator:
  - acc is WIN_BITS+1 wide.
  - While win_cnt != max: acc <= acc + pdm_s.
- End of window (win_cnt == 2^WIN_BITS-1):
  - Compute total = acc + pdm_s.
  - Compute scaled = total << (16-WIN_BITS).
  - Saturate to 0xFFFF if scaled > 0xFFFF. An all-ones window therefore yields 0xFFFF, not 0.
  - duty <= scaled, done <= 1, acc <= 0. The new window starts with the next sample and no sample is lost.
- done:
  - High exactly one clock, on the clock after the end-of-window edge.
  - Period is exactly 2^WIN_BITS clocks.
  - First done appears 2^WIN_BITS clocks after reset release.
  - The first window includes the 2 zero samples from the synchronizer flush.
- duty is held stable between done pulses.
- No handshake or back-pressure: a consumer must capture duty on done or before the next done.
- Widths:
  - acc never overflows, since its maximum is 2^WIN_BITS.
  - All arithmetic is unsigned.

Optional Feature:
- Macro: INV_PDM_AVG_EN.
- Defined:
  - A 16-bit prev_duty register holds the previous window's saturated result. It resets to 0.
  - On each end-of-window, duty <= (prev_duty + scaled_sat) >> 1, computed with a 17-bit sum. Then prev_duty <= scaled_sat.
  - done timing is unchanged.
  - The first report after reset is half the first window's value.
- Not defined:
  - duty equals the current window's saturated value.
  - No prev_duty register exists.

Test Plan:
1. PDM held 0, WIN_BITS=16 → done every 65536 clocks; duty=0x0000.
2. PDM held 1, WIN_BITS=16:
   - first window → duty=0xFFFE (the 2 flush zeros give 65534 ones);
   - second and later windows → duty=0xFFFF (saturated).
3. PDM toggling every clock (50 %), WIN_BITS=16 → steady-state duty=0x8000 ±1; done is exactly one cycle wide.
4. PDM pattern 1000 repeating (25 %), WIN_BITS=8 → done every 256 clocks; steady-state duty=0x4000.
5. Reset mid-window (assert rst_n=0 at win_cnt≈30000 for 3 clocks, PDM=1) → duty=0 and done=0 immediately; next done 65536 clocks after release.
6. INV_PDM_AVG_EN defined, WIN_BITS=8:
   - 50 % for one window → duty 0x4000 (averaged with reset 0);
   - then PDM=1 → duty 0xBFFF or 0xC000 (pipeline-dependent, window may straddle the change);
   - subsequent windows → 0xFFFF.
